mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares a single WIDTH-bit memory port between an instruction-fetch requester (port 0) and a data-access requester (port 1). It grants the port with round-robin priority and steers the granted requester's address, write data and write-enable onto the port through a 2:1 select. It holds the grant until the memory acknowledges or a watchdog expires. It sits between the CPU's fetch/load-store logic and the shared memory model.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and data access (port 1), with a watchdog that aborts stalled transactions.
module mem_port_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_prio;
  logic [7:0] r_wd;

  logic w_busy;
  logic w_we;

  assign w_busy = (r_state == BUSY);
  assign w_we   = gnt1 ? we1 : we0;

  // The grant register alone steers the port; IDLE forces every port output low.
  assign mem_req   = w_busy;
  assign mem_we    = w_busy & w_we;
  assign mem_addr  = w_busy ? (gnt1 ? addr1 : addr0) : '0;
  assign mem_wdata = w_busy ? (gnt1 ? wdata1 : wdata0) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_wd    <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_wd    <= '0;
            r_state <= BUSY;
            if (req0 && (!req1 || !r_prio)) gnt0 <= 1'b1;
            else                            gnt1 <= 1'b1;
          end
        end
        BUSY: begin
          // Ack is checked before the watchdog so a last-cycle ack still completes.
          if (mem_ack) begin
            if (!w_we) rdata <= mem_rdata;
            done0   <= gnt0;
            done1   <= gnt1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            r_prio  <= !gnt1;
            r_state <= IDLE;
          end else if (r_wd == WD_LAST) begin
            err     <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            r_prio  <= !gnt1;
            r_state <= IDLE;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, built with TIMEOUT=4.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic        gnt0, gnt1, done0, done1, err;
  logic [15:0] rdata;
  logic        mem_req;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int testsRun  = 0;
  int failCount = 0;

  mem_port_arbiter #(.WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err(err),
    .rdata(rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [15:0] expRdata);
    checkOutput({tag, ".gnt"},   {30'd0, gnt1, gnt0}, 32'd0);
    checkOutput({tag, ".pulse"}, {29'd0, err, done1, done0}, 32'd0);
    checkOutput({tag, ".rdata"}, {16'd0, rdata}, {16'd0, expRdata});
    checkOutput({tag, ".port"},  {mem_req, mem_we, mem_addr, 14'd0}, 32'd0);
    checkOutput({tag, ".wdata"}, {16'd0, mem_wdata}, 32'd0);
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic ack, input logic [15:0] rd);
    req0      = r0;
    req1      = r1;
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    checkIdle("reset", 16'h0000);
    rst = 1'b0;

    // Single read from port 0
    addr0 = 16'h0040; we0 = 1'b0;
    applyStimulus(1, 0, 0, 16'h0000);
    tick();
    checkOutput("rd.gnt0", {30'd0, gnt1, gnt0}, 32'd1);
    checkOutput("rd.mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("rd.mem_addr", {16'd0, mem_addr}, 32'h0040);
    checkOutput("rd.mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    checkOutput("rd.done_early", {31'd0, done0}, 32'd0);
    applyStimulus(1, 0, 1, 16'hBEEF);
    tick();
    checkOutput("rd.done0", {30'd0, done1, done0}, 32'd1);
    checkOutput("rd.rdata", {16'd0, rdata}, 32'hBEEF);
    checkOutput("rd.gnt_low", {30'd0, gnt1, gnt0}, 32'd0);
    checkOutput("rd.mem_req_low", {31'd0, mem_req}, 32'd0);
    applyStimulus(0, 0, 0, 16'h0000);
    tick();
    checkIdle("rd.after", 16'hBEEF);

    // Write routing on port 1; read data in the ack cycle must be ignored
    addr1 = 16'h1234; wdata1 = 16'h00FF; we1 = 1'b1;
    applyStimulus(0, 1, 0, 16'h0000);
    tick();
    checkOutput("wr.gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    checkOutput("wr.mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("wr.mem_addr", {16'd0, mem_addr}, 32'h1234);
    checkOutput("wr.mem_wdata", {16'd0, mem_wdata}, 32'h00FF);
    applyStimulus(0, 1, 1, 16'hDEAD);
    tick();
    checkOutput("wr.done1", {30'd0, done1, done0}, 32'd2);
    checkOutput("wr.rdata_kept", {16'd0, rdata}, 32'hBEEF);
    applyStimulus(0, 0, 0, 16'h0000);
    we1 = 1'b0;

    // Contention from reset: ack held high, grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("cont.reset", 16'h0000);
    addr1 = 16'h2000;
    applyStimulus(1, 1, 1, 16'h1111);
    for (int c = 1; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("cont.gnt.c%0d", c), {30'd0, gnt1, gnt0},
                  (c == 1 || c == 5) ? 32'd1 : (c == 3 || c == 7) ? 32'd2 : 32'd0);
      checkOutput($sformatf("cont.done.c%0d", c), {30'd0, done1, done0},
                  (c == 2 || c == 6) ? 32'd1 : (c == 4 || c == 8) ? 32'd2 : 32'd0);
    end
    checkOutput("cont.rdata", {16'd0, rdata}, 32'h1111);
    applyStimulus(0, 0, 0, 16'h0000);
    tick();

    // Timeout on port 0 with TIMEOUT=4, then a contended request goes to port 1
    applyStimulus(1, 0, 0, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      tick();
      checkOutput($sformatf("to.err.c%0d", c), {31'd0, err}, (c == 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("to.done.c%0d", c), {30'd0, done1, done0}, 32'd0);
      checkOutput($sformatf("to.gnt0.c%0d", c), {31'd0, gnt0}, (c < 5) ? 32'd1 : 32'd0);
    end
    applyStimulus(1, 1, 0, 16'h0000);
    tick();
    checkOutput("to.prio_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    checkOutput("to.err_cleared", {31'd0, err}, 32'd0);
    applyStimulus(0, 1, 1, 16'h5A5A);
    tick();
    checkOutput("to.done1", {30'd0, done1, done0}, 32'd2);
    checkOutput("to.rdata", {16'd0, rdata}, 32'h5A5A);
    checkOutput("to.no_err", {31'd0, err}, 32'd0);
    applyStimulus(0, 0, 0, 16'h0000);
    tick();

    // Ack in the 4th BUSY cycle collides with the watchdog; ack wins
    applyStimulus(1, 0, 0, 16'h0000);
    tick(); tick(); tick(); tick();
    checkOutput("edge.gnt0_c4", {30'd0, gnt1, gnt0}, 32'd1);
    applyStimulus(1, 0, 1, 16'hC0DE);
    tick();
    checkOutput("edge.done0", {30'd0, done1, done0}, 32'd1);
    checkOutput("edge.no_err", {31'd0, err}, 32'd0);
    checkOutput("edge.rdata", {16'd0, rdata}, 32'hC0DE);
    applyStimulus(0, 0, 0, 16'h0000);
    tick();
    checkOutput("edge.err_after", {31'd0, err}, 32'd0);

    // Reset in the 2nd BUSY cycle, then a late ack; prio must be back at 0
    applyStimulus(0, 1, 0, 16'h0000);
    tick();
    checkOutput("rst.gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("rst.cleared", 16'h0000);
    applyStimulus(0, 0, 1, 16'h7777);
    tick();
    checkIdle("rst.late_ack", 16'h0000);
    applyStimulus(1, 1, 0, 16'h0000);
    tick();
    checkOutput("rst.next_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
    applyStimulus(1, 1, 1, 16'h0001);
    tick();
    checkOutput("rst.done0", {30'd0, done1, done0}, 32'd1);
    applyStimulus(0, 0, 0, 16'h0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
